// File: rtl/round_controller_pkg.sv
// Shared codes for the fighting-match round controller and the player FSMs.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package round_controller_pkg;

   // Player FSM state codes that carry damage meaning
   localparam logic [3:0] S_HITSTUN   = 4'd9;
   localparam logic [3:0] S_BLOCKSTUN = 4'd10;

   // Match phase encoding, visible on the phase output
   typedef enum logic [2:0] {
      PH_IDLE      = 3'd0,
      PH_INTRO     = 3'd1,
      PH_FIGHT     = 3'd2,
      PH_ROUND_END = 3'd3,
      PH_MATCH_END = 3'd4
   } phase_e;

   // match_winner encoding
   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2,
      WIN_DRAW = 2'd3
   } winner_e;

   // Two-bit counter increment that sticks at 3
   function automatic logic [1:0] sat_inc2(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

endpackage

// File: rtl/round_controller_vital.sv
// Per-player health/guard counter with state-entry damage detection.
// Latency: damage shows on health/block one cycle after the stun code enters.
// Backpressure: none; reload has priority over damage, damage needs en.
module vital_counter
   import round_controller_pkg::*;
#(
   parameter int MAX_HEALTH = 3,
   parameter int MAX_BLOCK  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state_in,
   input  logic       reload,
   input  logic       en,
   output logic [2:0] health,
   output logic [2:0] block,
   output logic       ko
);

   localparam logic [2:0] HEALTH_INIT = 3'(MAX_HEALTH);
   localparam logic [2:0] BLOCK_INIT  = 3'(MAX_BLOCK);

   logic [3:0] prev_q, prev_d;
   logic [2:0] health_q, health_d;
   logic [2:0] block_q, block_d;
   logic       hit_edge, blk_edge;

   // Detect stun entries and compute the saturating health/guard update
   always_comb begin
      hit_edge = (state_in == S_HITSTUN)   && (prev_q != S_HITSTUN);
      blk_edge = (state_in == S_BLOCKSTUN) && (prev_q != S_BLOCKSTUN);
      prev_d   = state_in;
      health_d = health_q;
      block_d  = block_q;
      if (reload) begin
         health_d = HEALTH_INIT;
         block_d  = BLOCK_INIT;
      end else if (en) begin
         if (hit_edge && (health_q != 3'd0)) begin
            health_d = health_q - 3'd1;
         end
         if (blk_edge) begin
            if (block_q != 3'd0) begin
               block_d = block_q - 3'd1;
            end else if (health_q != 3'd0) begin
               // guard is broken: the blocked hit lands on health
               health_d = health_q - 3'd1;
            end
         end
      end
   end

   // Previous-state tracking runs every cycle so stun held across FIGHT entry is not damage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q   <= 4'd0;
         health_q <= HEALTH_INIT;
         block_q  <= BLOCK_INIT;
      end else begin
         prev_q   <= prev_d;
         health_q <= health_d;
         block_q  <= block_d;
      end
   end

   assign health = health_q;
   assign block  = block_q;
   assign ko     = (health_q == 3'd0);

endmodule

// File: rtl/round_controller.sv
// Match sequencer: phase FSM, round timer, round/draw counting and winner decision.
// Latency: all outputs registered; round end is decided the cycle after the deciding damage.
// Backpressure: none; start is only honoured in IDLE and MATCH_END.
module round_controller
   import round_controller_pkg::*;
#(
   parameter int MAX_HEALTH    = 3,
   parameter int MAX_BLOCK     = 3,
   parameter int ROUND_SECS    = 60,
   parameter int TICKS_PER_SEC = 60,
   parameter int ROUNDS_TO_WIN = 2,
   parameter int INTRO_TICKS   = 90,
   parameter int KO_TICKS      = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic [3:0] p1_state,
   input  logic [3:0] p2_state,
   output logic [2:0] p1_health,
   output logic [2:0] p2_health,
   output logic [2:0] p1_block,
   output logic [2:0] p2_block,
   output logic [1:0] p1_rounds,
   output logic [1:0] p2_rounds,
   output logic [6:0] timer_secs,
   output logic [2:0] phase,
   output logic       fight_active,
   output logic [1:0] match_winner
);

   localparam logic [7:0] INTRO_LAST = 8'(INTRO_TICKS - 1);
   localparam logic [7:0] KO_LAST    = 8'(KO_TICKS - 1);
   localparam logic [6:0] PRE_LAST   = 7'(TICKS_PER_SEC - 1);
   localparam logic [6:0] SECS_INIT  = 7'(ROUND_SECS);
   localparam logic [1:0] WIN_ROUNDS = 2'(ROUNDS_TO_WIN);

   phase_e     phase_q, phase_d;
   logic [7:0] cnt_q, cnt_d;
   logic [6:0] pre_q, pre_d;
   logic [6:0] timer_q, timer_d;
   logic [1:0] p1_rounds_q, p1_rounds_d;
   logic [1:0] p2_rounds_q, p2_rounds_d;
   logic [1:0] draws_q, draws_d;
   winner_e    winner_q, winner_d;
   logic       fight_q, fight_d;

   logic       reload, dmg_en, enter_intro, round_over;
   logic       p1_ko, p2_ko;

   vital_counter #(.MAX_HEALTH(MAX_HEALTH), .MAX_BLOCK(MAX_BLOCK)) u_p1 (
      .clk      (clk),
      .rst      (rst),
      .state_in (p1_state),
      .reload   (reload),
      .en       (dmg_en),
      .health   (p1_health),
      .block    (p1_block),
      .ko       (p1_ko)
   );

   vital_counter #(.MAX_HEALTH(MAX_HEALTH), .MAX_BLOCK(MAX_BLOCK)) u_p2 (
      .clk      (clk),
      .rst      (rst),
      .state_in (p2_state),
      .reload   (reload),
      .en       (dmg_en),
      .health   (p2_health),
      .block    (p2_block),
      .ko       (p2_ko)
   );

   // Phase sequencing, round timer and round/draw bookkeeping
   always_comb begin
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      pre_d       = pre_q;
      timer_d     = timer_q;
      p1_rounds_d = p1_rounds_q;
      p2_rounds_d = p2_rounds_q;
      draws_d     = draws_q;
      winner_d    = winner_q;
      reload      = 1'b0;
      dmg_en      = 1'b0;
      enter_intro = 1'b0;
      round_over  = 1'b0;

      case (phase_q)
         PH_IDLE, PH_MATCH_END: begin
            if (start) begin
               p1_rounds_d = 2'd0;
               p2_rounds_d = 2'd0;
               draws_d     = 2'd0;
               winner_d    = WIN_NONE;
               enter_intro = 1'b1;
            end
         end
         PH_INTRO: begin
            if (tick) begin
               if (cnt_q == INTRO_LAST) begin
                  cnt_d   = 8'd0;
                  phase_d = PH_FIGHT;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         PH_FIGHT: begin
            // decisions use registered health, so the deciding hit is already visible
            round_over = 1'b1;
            if (p1_ko && p2_ko) begin
               draws_d = sat_inc2(draws_q);
            end else if (p2_ko) begin
               p1_rounds_d = sat_inc2(p1_rounds_q);
            end else if (p1_ko) begin
               p2_rounds_d = sat_inc2(p2_rounds_q);
            end else if (timer_q == 7'd0) begin
               if (p1_health > p2_health) begin
                  p1_rounds_d = sat_inc2(p1_rounds_q);
               end else if (p2_health > p1_health) begin
                  p2_rounds_d = sat_inc2(p2_rounds_q);
               end else begin
                  draws_d = sat_inc2(draws_q);
               end
            end else begin
               round_over = 1'b0;
            end

            if (round_over) begin
               phase_d = PH_ROUND_END;
               cnt_d   = 8'd0;
            end else begin
               dmg_en = 1'b1;
               if (tick) begin
                  if (pre_q == PRE_LAST) begin
                     pre_d = 7'd0;
                     if (timer_q != 7'd0) begin
                        timer_d = timer_q - 7'd1;
                     end
                  end else begin
                     pre_d = pre_q + 7'd1;
                  end
               end
            end
         end
         PH_ROUND_END: begin
            if (tick) begin
               if (cnt_q == KO_LAST) begin
                  cnt_d = 8'd0;
                  if (p1_rounds_q == WIN_ROUNDS) begin
                     winner_d = WIN_P1;
                     phase_d  = PH_MATCH_END;
                  end else if (p2_rounds_q == WIN_ROUNDS) begin
                     winner_d = WIN_P2;
                     phase_d  = PH_MATCH_END;
                  end else if (draws_q == 2'd3) begin
                     winner_d = WIN_DRAW;
                     phase_d  = PH_MATCH_END;
                  end else begin
                     enter_intro = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            phase_d = PH_IDLE;
         end
      endcase

      // every path into INTRO starts a fresh round
      if (enter_intro) begin
         phase_d = PH_INTRO;
         cnt_d   = 8'd0;
         pre_d   = 7'd0;
         timer_d = SECS_INIT;
         reload  = 1'b1;
      end
   end

   assign fight_d = (phase_d == PH_FIGHT);

   // State registers; reset returns to IDLE with a full round loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= PH_IDLE;
         cnt_q       <= 8'd0;
         pre_q       <= 7'd0;
         timer_q     <= SECS_INIT;
         p1_rounds_q <= 2'd0;
         p2_rounds_q <= 2'd0;
         draws_q     <= 2'd0;
         winner_q    <= WIN_NONE;
         fight_q     <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         pre_q       <= pre_d;
         timer_q     <= timer_d;
         p1_rounds_q <= p1_rounds_d;
         p2_rounds_q <= p2_rounds_d;
         draws_q     <= draws_d;
         winner_q    <= winner_d;
         fight_q     <= fight_d;
      end
   end

   assign p1_rounds    = p1_rounds_q;
   assign p2_rounds    = p2_rounds_q;
   assign timer_secs   = timer_q;
   assign phase        = phase_q;
   assign fight_active = fight_q;
   assign match_winner = winner_q;

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Sequences a fighting match. Owns per-player health and guard (block) counters, applies damage and guard wear from the player state codes, and detects KO and time-out.
- Runs the round timer, counts round wins and declares the match winner.
- Sits between the two player FSMs and the display/renderer. Its fight_active output gates player input.

Parameters:
- MAX_HEALTH, 3, health value loaded at each round start (1..7)
- MAX_BLOCK, 3, guard value loaded at each round start (1..7)
- ROUND_SECS, 60, round time in seconds (1..99)
- TICKS_PER_SEC, 60, tick pulses per displayed second
- ROUNDS_TO_WIN, 2, round wins that end the match (1..3)
- INTRO_TICKS, 90, ticks spent in INTRO before FIGHT
- KO_TICKS, 120, ticks spent in ROUND_END before the next round

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset
- tick, in, 1, one-cycle frame pulse; all timers advance only on tick
- start, in, 1, one-cycle pulse; starts a match from IDLE or MATCH_END
- p1_state, in, 4, player 1 FSM state code
- p2_state, in, 4, player 2 FSM state code
- p1_health, out, 3, player 1 health
- p2_health, out, 3, player 2 health
- p1_block, out, 3, player 1 guard
- p2_block, out, 3, player 2 guard
- p1_rounds, out, 2, player 1 rounds won
- p2_rounds, out, 2, player 2 rounds won
- timer_secs, out, 7, seconds remaining
- phase, out, 3, current phase code
- fight_active, out, 1, high only in FIGHT
- match_winner, out, 2, 0 none, 1 P1, 2 P2, 3 draw-limit

Behaviour:
- Clock and reset: clk; rst is asynchronous, active-high.
- Reset state:
  - phase IDLE.
  - Health = MAX_HEALTH, block = MAX_BLOCK.
  - Rounds = 0, timer_secs = ROUND_SECS, fight_active = 0, match_winner = 0.
  - Tick prescaler = 0, draw counter = 0.
- Phases: IDLE=0, INTRO=1, FIGHT=2, ROUND_END=3, MATCH_END=4. phase is registered.
- IDLE:
  - On start: rounds = 0 and go to INTRO.
- INTRO:
  - On entry: reload health, block, timer_secs and prescaler.
  - After INTRO_TICKS ticks, go to FIGHT.
- Damage, FIGHT only:
  - Edge-triggered. Register the previous state code per player.
  - Entry into HITSTUN (code 9; previous code != 9): health -1, saturating at 0.
  - Entry into BLOCKSTUN (code 10; previous code != 10):
    - If block > 0: block -1.
    - Else (guard broken): health -1, saturating.
  - Remaining in state 9 or 10 does not decrement.
  - Both players are evaluated in the same cycle, independently.
  - The previous-state registers update every cycle in every phase. A player already in stun when FIGHT begins is therefore not damaged.
- Timer:
  - Prescaler counts ticks 0..TICKS_PER_SEC-1.
  - On wrap, timer_secs -1. It stops at 0.
- FIGHT exit, evaluated on registered health the cycle after damage applies; priority top-down:
  1. Both health = 0: draw.
  2. One player's health = 0: the other player wins the round.
  3. timer_secs = 0: the higher health wins; equal health is a draw.
  - The winner's rounds counter +1 (saturating at 3). A draw increments the internal draw counter (2 bits).
  - Then go to ROUND_END with fight_active = 0.
  - Health, block and timer are frozen outside FIGHT.
- ROUND_END, after KO_TICKS ticks:
  - If p1_rounds = ROUNDS_TO_WIN: match_winner = 1, go to MATCH_END.
  - Else if p2_rounds = ROUNDS_TO_WIN: match_winner = 2, go to MATCH_END.
  - Else if draw counter = 3: match_winner = 3, go to MATCH_END.
  - Else go to INTRO.
- MATCH_END:
  - Outputs hold.
  - On start: clear rounds, draw counter and match_winner, then go to INTRO.
- start is ignored in INTRO, FIGHT and ROUND_END.
- rst mid-round returns to IDLE immediately, with all reset values restored.

Decomposition:
- Shared package holds:
  - Player state codes (S_HITSTUN = 9, S_BLOCKSTUN = 10) for use by the player FSMs and this block.
  - Phase codes and match_winner encodings.
- Sub-module vital_counter, instantiated twice (one per player). It contains:
  - The previous-state register and edge detection.
  - Saturating health and block decrement.
  - Reload and enable inputs.
  - ko flag output.
- The phase FSM, timer and round counters stay in the top level.

Test Plan:
- start, then 90 ticks → phase goes 0→1→2 and fight_active = 1. Health 3/3, block 3/3, timer_secs 60.
- Hold p2_state = 9 for 10 cycles → p2_health 3→2 once only. Return p2_state to 0, then 9 again → 1.
- Enter p1 BLOCKSTUN four times (separate entries) → p1_block 3,2,1,0. The fourth entry gives p1_health 3→2 (guard break).
- Apply three separate p2 hit entries → p2_health = 0 and phase = 3 with p1_rounds = 1. After 120 ticks → phase = 1 with health reloaded. A second p1 round win → match_winner = 1, phase = 4.
- Timer expiry with p1_health = 2, p2_health = 2 → draw, no round awarded. Three consecutive draws → match_winner = 3.
- Both players enter HITSTUN in the same cycle at health 1 → draw, rounds unchanged. Assert rst during FIGHT → all outputs at reset values, phase 0.
